// File: rtl/seq_alu.sv
// Registered ALU with a multi-cycle shift-add multiplier and restoring divider.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise divu (1100) reports an illegal opcode.
module seq_alu #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alucontrol,
  input  logic [n-1:0] srcA,
  input  logic [n-1:0] srcB,
  output logic [n-1:0] out,
  output logic [n-1:0] hi,
  output logic         zero,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   dbg_state
);
  localparam int MUL_CYCLES = n;
  localparam int SW = $clog2(n);
  localparam int CW = $clog2(n) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_MULU = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
`ifdef SEQ_ALU_DIV_EN
    , S_DIV = 2'd3
`endif
  } state_t;

  // Handshake: start is taken only in IDLE or DONE (busy=0); done pulses for
  // exactly one cycle when out/hi/zero/err take a new result.
  state_t         state_q, state_d;
  logic [n-1:0]   out_q, out_d, hi_q, hi_d;
  logic           zero_q, zero_d, err_q, err_d;
  logic [2*n-1:0] prod_q, prod_d;
  logic [n-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [n-1:0]   alu_res;
  logic           alu_ill;
  logic [SW-1:0]  shamt;
  logic [n:0]     mul_sum;
  logic [2*n-1:0] mul_nx;

  assign shamt = srcB[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alucontrol)
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_ADD:  alu_res = srcA + srcB;
      OP_SLL:  alu_res = srcA << shamt;
      OP_NOR:  alu_res = ~(srcA | srcB);
      OP_SUB:  alu_res = srcA - srcB;
      OP_SLT:  alu_res = {{(n-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SRL:  alu_res = srcA >> shamt;
      OP_SRA:  alu_res = $signed(srcA) >>> shamt;
      OP_XOR:  alu_res = srcA ^ srcB;
      OP_SLTU: alu_res = {{(n-1){1'b0}}, (srcA < srcB)};
      default: alu_ill = 1'b1;
    endcase
  end

  // prod_q holds {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*n-1:n]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx  = {mul_sum, prod_q[n-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic [n:0]     rem_ext, rem_diff;
  logic [2*n-1:0] div_nx;
  // prod_q holds {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    rem_ext  = prod_q[2*n-1:n-1];
    rem_diff = rem_ext - {1'b0, opnd_q};
    if (!rem_diff[n]) div_nx = {rem_diff[n-1:0], prod_q[n-2:0], 1'b1};
    else              div_nx = {rem_ext[n-1:0],  prod_q[n-2:0], 1'b0};
  end
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    err_d   = err_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          cnt_d = '0;
          if (alucontrol == OP_MULU) begin
            state_d = S_MUL;
            opnd_d  = srcA;
            prod_d  = {{n{1'b0}}, srcB};
`ifdef SEQ_ALU_DIV_EN
          end else if (alucontrol == OP_DIVU) begin
            if (srcB == '0) begin
              state_d = S_DONE;
              out_d   = '1;
              hi_d    = srcA;
              err_d   = 1'b1;
            end else begin
              state_d = S_DIV;
              opnd_d  = srcB;
              prod_d  = {{n{1'b0}}, srcA};
            end
`endif
          end else begin
            state_d = S_DONE;
            out_d   = alu_res;
            hi_d    = '0;
            err_d   = alu_ill;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          state_d = S_DONE;
          out_d   = mul_nx[n-1:0];
          hi_d    = mul_nx[2*n-1:n];
          err_d   = 1'b0;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV: begin
        prod_d = div_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          state_d = S_DONE;
          out_d   = div_nx[n-1:0];
          hi_d    = div_nx[2*n-1:n];
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      prod_q  <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
`ifdef SEQ_ALU_DIV_EN
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
`else
  assign busy      = (state_q == S_MUL);
`endif
  assign dbg_state = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (n=16): latency, results, handshake, reset abort.
module tb_seq_alu;
  localparam int N = 16;
  localparam int W = 2 * N + 1;

  logic         clk, reset, start;
  logic [3:0]   alucontrol;
  logic [N-1:0] src_a, src_b;
  logic [N-1:0] out, hi;
  logic         zero, busy, done, err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  seq_alu #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .srcA(src_a), .srcB(src_b), .out(out), .hi(hi), .zero(zero),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge k).
  // Returns at the negedge of the done cycle (or after the cycle budget).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int exp_lat, input logic [N-1:0] e_out,
                        input logic [N-1:0] e_hi, input logic e_err, input bit poke_mid);
    int cyc;
    int busy_cyc;
    logic [W-1:0] exp_v;
    exp_q.push_back({e_err, e_hi, e_out});
    start = 1'b1; alucontrol = op; src_a = a; src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alucontrol = 4'hF; src_a = ~a; src_b = ~b;
    cyc = 1;
    busy_cyc = 0;
    while (!done && cyc < 64) begin
      if (busy) busy_cyc++;
      start = (poke_mid && cyc == 5);
      alucontrol = 4'h0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    check({tag, "/done"}, done, 1);
    check({tag, "/latency"}, cyc, exp_lat);
    check({tag, "/busy_cycles"}, busy_cyc, exp_lat - 1);
    check({tag, "/busy_in_done"}, busy, 0);
    check({tag, "/out"}, out, exp_v[N-1:0]);
    check({tag, "/hi"}, hi, exp_v[2*N-1:N]);
    check({tag, "/err"}, err, exp_v[W-1]);
    check({tag, "/zero"}, zero, (exp_v[N-1:0] == '0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/state"}, dbg_state, 2'd0);
    check({tag, "/out"}, out, 0);
    check({tag, "/hi"}, hi, 0);
    check({tag, "/zero"}, zero, 1);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/err"}, err, 0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; alucontrol = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    check_reset_state("idle");

    run_op("add_wrap", 4'b0010, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("slt_neg",  4'b0111, 16'h8000, 16'h0001, 1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("sub_wrap", 4'b0110, 16'h0005, 16'h0007, 1, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("sra",      4'b1001, 16'h8000, 16'h0014, 1, 16'hF800, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("srl",      4'b1000, 16'h8000, 16'h0001, 1, 16'h4000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("nor",      4'b0101, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("sltu",     4'b1011, 16'h8000, 16'h0001, 1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("xor",      4'b1010, 16'hA5A5, 16'hFFFF, 1, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("and_or",   4'b0001, 16'hF000, 16'h000F, 1, 16'hF00F, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("mulu",     4'b0100, 16'h1234, 16'h5678, 17, 16'h0060, 16'h0626, 1'b0, 1'b1);
    @(negedge clk);
    run_op("mulu_max", 4'b0100, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
`ifdef SEQ_ALU_DIV_EN
    run_op("divu",     4'b1100, 16'd100, 16'd7, 17, 16'd14, 16'd2, 1'b0, 1'b0);
    @(negedge clk);
    run_op("divu_zero", 4'b1100, 16'd100, 16'd0, 1, 16'hFFFF, 16'd100, 1'b1, 1'b0);
`else
    run_op("divu_off", 4'b1100, 16'd100, 16'd7, 1, 16'h0000, 16'h0000, 1'b1, 1'b0);
`endif
    @(negedge clk);

    // Reset in cycle k+5 of a multiply aborts it without a done pulse.
    start = 1'b1; alucontrol = 4'b0100; src_a = 16'h00FF; src_b = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort/busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort/no_done", done_seen, 0);
    run_op("add_after", 4'b0010, 16'd3, 16'd4, 1, 16'd7, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);

    // Reset and start in the same cycle: start dropped.
    start = 1'b1; reset = 1'b1; alucontrol = 4'b0010; src_a = 16'd1; src_b = 16'd1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_start/done", done, 0);
    check("rst_start/state", dbg_state, 2'd0);

    // Back-to-back: illegal opcode started in the sll done cycle.
    run_op("sll", 4'b0011, 16'h0001, 16'h0013, 1, 16'h0008, 16'h0000, 1'b0, 1'b0);
    run_op("b2b_illegal", 4'b1111, 16'h1234, 16'h0001, 1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b/idle_after", dbg_state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the MIPS-style datapath. It adds a multi-cycle multiply/divide unit to the single-cycle logic and arithmetic operations, with a start/busy/done handshake. All results are registered. Multiply and divide return a full double-width result on `out` (low half) and `hi` (high half). It sits in the EX stage; the controller stalls on `busy`.

## Interface
- `n`, default 16: operand and result width; legal for n ≥ 4.
- `MUL_CYCLES`, default `n` (fixed, not overridable): iteration count of the shift-add multiplier and the restoring divider.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `alucontrol`  in  4  operation code, latched with `start`
- `srcA`, `srcB`  in  n  operands, latched with `start`
- `out`  out  n  result; low half for mul/div
- `hi`  out  n  high product (mul), remainder (div), else 0
- `zero`  out  1  `out`==0, registered with `out`
- `busy`  out  1  multi-cycle operation in progress
- `done`  out  1  one-cycle pulse when `out`/`hi`/`zero`/`err` update
- `err`  out  1  illegal opcode or divide by zero for the reported result

## Operation
- Opcodes:
  - 0000 and, 0001 or, 0010 add, 0011 sll, 0101 nor, 0110 sub
  - 0111 slt (signed; 1 if A<B, else 0)
  - 1000 srl, 1001 sra, 1010 xor, 1011 sltu
  - 0100 mulu (multi-cycle)
  - 1100 divu (multi-cycle)
  - 1101–1111 illegal
- Shifts use `srcB[$clog2(n)-1:0]`; upper bits are ignored.
- add/sub wrap modulo 2^n; no overflow flag.
- States:
  - IDLE: `busy`=0. On `start`, latch operands. Single-cycle op → DONE. mulu → MUL. divu → DIV.
  - MUL: shift-add, one bit per cycle, for n cycles → DONE. {`hi`,`out`} = A*B, unsigned, 2n bits.
  - DIV: restoring division, one bit per cycle, for n cycles → DONE. `out`=A/B, `hi`=A%B, unsigned.
  - DONE: `done`=1 for one cycle, `busy`=0. `start` is accepted here (back-to-back), otherwise → IDLE.
- `start` while `busy`=1 is ignored, with no queueing. Operand and opcode changes during `busy` have no effect.
- Divide by zero: does not iterate; goes directly to DONE. `out`=all ones, `hi`=A, `err`=1.
- Illegal opcode: goes to DONE. `out`=0, `hi`=0, `zero`=1, `err`=1.
- Outputs hold their last result until the next `done`.

## Timing
- Reset: state=IDLE; `out`=0, `hi`=0, `zero`=1, `busy`=0, `done`=0, `err`=0.
- `start` sampled at edge k:
  - Single-cycle, illegal, or div-by-zero: `done`=1 and results valid in cycle k+1.
  - mulu/divu: `busy`=1 in cycles k+1..k+n; `done`=1 and results valid in cycle k+n+1.
- Back-to-back: `start` in the DONE cycle begins the next operation at that edge; the next `done` follows at the same latency.
- Reset during MUL/DIV aborts the operation. Next cycle is IDLE with reset values; no `done` pulse for the aborted operation.
- Reset and `start` in the same cycle: reset wins; `start` is dropped.

## Configuration
- `SEQ_ALU_DIV_EN`:
  - Defined: divu (1100) is implemented as above.
  - Undefined: no divider logic is generated. 1100 is treated as an illegal opcode (`err`=1, single-cycle `done`). The DIV state does not exist.

## Test plan
- Reset then idle → `out`=0, `hi`=0, `zero`=1, `busy`=0, `done`=0, `err`=0.
- n=16, add, A=16'hFFFF, B=16'h0001, `start` at edge k → `done` at k+1, `out`=0, `zero`=1. Follow with slt A=16'h8000, B=1 → `out`=1.
- mulu A=16'h1234, B=16'h5678 → `busy` for 16 cycles, `done` at k+17, {`hi`,`out`}=32'h0626_0060. A `start` pulsed mid-operation is ignored.
- divu A=100, B=7 → `out`=14, `hi`=2, `err`=0 at k+17. divu B=0 → `out`=16'hFFFF, `hi`=100, `err`=1 at k+1. Without `SEQ_ALU_DIV_EN`: 1100 → `err`=1, `out`=0 at k+1.
- Reset asserted at cycle k+5 of a mulu → no `done`; cycle after reset shows IDLE and reset values. A subsequent add completes normally.
- Back-to-back: sll A=1, B=16'h0013 (shift 3) → `out`=8. `start` in that DONE cycle with opcode 1111 → next cycle `done`=1, `err`=1, `out`=0.
